// File: rtl/op_amp_gain_array.sv
// Multi-channel fractional-gain amplifier: samples all channels on an internal strobe,
// then streams saturated outputs and their squares through one shared multiplier.
//
// state  | meaning
// S_IDLE | waiting for sample_tick; snapshot inputs on the tick
// S_GAIN | register x * g_eff for the current channel
// S_SQR  | register saturated amplitude, clip flag and its square
// S_OUT  | hold result with out_valid until out_ready
module op_amp_gain_array #(
    parameter int CHANNELS    = 4,
    parameter int IN_W        = 16,
    parameter int GAIN_INT_W  = 3,
    parameter int GAIN_FRAC_W = 8,
    parameter int DIV         = 1000,
    localparam int GW = GAIN_INT_W + GAIN_FRAC_W,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [CHANNELS*IN_W-1:0] non_inv,
    input  logic [CHANNELS*GW-1:0]   gain,
    input  logic [CHANNELS-1:0]      inv_mode,
    output logic                     sample_tick,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_chan,
    output logic signed [IN_W-1:0]   out_amp,
    output logic [2*IN_W-1:0]        out_square,
    output logic                     out_sat,
    output logic                     overrun
);

    localparam int MB   = (GW + 2 > IN_W) ? GW + 2 : IN_W;
    localparam int MP   = IN_W + MB;
    localparam int CNTW = $clog2(DIV);
    localparam logic [CNTW-1:0]       LAST_CNT = CNTW'(DIV - 1);
    localparam logic [CW-1:0]         LAST_CH  = CW'(CHANNELS - 1);
    localparam logic signed [GW+1:0]  G_ONE    = signed'((GW + 2)'(2 ** GAIN_FRAC_W));
    localparam logic signed [IN_W-1:0] AMP_MAX = {1'b0, {(IN_W - 1){1'b1}}};
    localparam logic signed [IN_W-1:0] AMP_MIN = {1'b1, {(IN_W - 1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_GAIN, S_SQR, S_OUT} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [CNTW-1:0]            r_cnt;
    logic [CHANNELS*IN_W-1:0]   r_x_sh;
    logic [CHANNELS*GW-1:0]     r_g_sh;
    logic [CHANNELS-1:0]        r_inv_sh;
    logic [CW-1:0]              r_ch;
    logic signed [MP-1:0]       r_p;
    logic signed [IN_W-1:0]     r_amp;
    logic [2*IN_W-1:0]          r_square;
    logic                       r_sat;
    logic                       r_overrun;

    logic                       w_tick;
    logic signed [IN_W-1:0]     w_x;
    logic [GW-1:0]              w_g;
    logic                       w_inv;
    logic signed [GW+1:0]       w_g_ext;
    logic signed [GW+1:0]       w_geff;
    logic signed [MP-1:0]       w_shift;
    logic [MP-IN_W:0]           w_top;
    logic                       w_ovf;
    logic signed [IN_W-1:0]     w_amp;
    logic signed [IN_W-1:0]     w_mul_a;
    logic signed [MB-1:0]       w_mul_b;
    logic signed [MP-1:0]       w_mul_p;

    assign w_tick      = enable && (r_cnt == LAST_CNT);
    assign sample_tick = w_tick;
    assign out_valid   = (r_state == S_OUT);
    assign out_chan    = r_ch;
    assign out_amp     = r_amp;
    assign out_square  = r_square;
    assign out_sat     = r_sat;
    assign overrun     = r_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_x     = r_x_sh[r_ch*IN_W +: IN_W];
    assign w_g     = r_g_sh[r_ch*GW +: GW];
    assign w_inv   = r_inv_sh[r_ch];
    assign w_g_ext = signed'({2'b00, w_g});
    assign w_geff  = w_inv ? -w_g_ext : w_g_ext + G_ONE;

    // Arithmetic shift floors toward -inf; clipping is detected by the bits above the sign.
    assign w_shift = r_p >>> GAIN_FRAC_W;
    assign w_top   = w_shift[MP-1:IN_W-1];
    assign w_ovf   = !((&w_top) || !(|w_top));
    assign w_amp   = w_ovf ? (w_shift[MP-1] ? AMP_MIN : AMP_MAX) : w_shift[IN_W-1:0];

    // One multiplier: x * g_eff in S_GAIN, amp * amp in S_SQR.
    always_comb begin
        w_mul_a = w_x;
        w_mul_b = MB'(w_geff);
        if (r_state == S_SQR) begin
            w_mul_a = w_amp;
            w_mul_b = MB'(w_amp);
        end
    end

    assign w_mul_p = w_mul_a * w_mul_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_next = S_GAIN;
            S_GAIN:  w_next = S_SQR;
            S_SQR:   w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = (r_ch == LAST_CH) ? S_IDLE : S_GAIN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x_sh    <= '0;
            r_g_sh    <= '0;
            r_inv_sh  <= '0;
            r_ch      <= '0;
            r_p       <= '0;
            r_amp     <= '0;
            r_square  <= '0;
            r_sat     <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_x_sh   <= non_inv;
                        r_g_sh   <= gain;
                        r_inv_sh <= inv_mode;
                        r_ch     <= '0;
                    end
                end
                S_GAIN: r_p <= w_mul_p;
                S_SQR: begin
                    r_amp    <= w_amp;
                    r_sat    <= w_ovf;
                    r_square <= w_mul_p[2*IN_W-1:0];
                end
                S_OUT: begin
                    if (out_ready && (r_ch != LAST_CH)) r_ch <= r_ch + 1'b1;
                end
                default: ;
            endcase
            if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_op_amp_gain_array.sv
// Bench for op_amp_gain_array: directed frames with literal expectations plus a
// randomized run, all checked every cycle against an arithmetic reference model.
module tb_op_amp_gain_array;

    localparam int CH   = 4;
    localparam int IN_W = 16;
    localparam int GI   = 3;
    localparam int GF   = 8;
    localparam int GW   = GI + GF;
    localparam int DIV  = 20;
    localparam int CW   = 2;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   enable = 1'b0;
    logic                   out_ready = 1'b0;
    logic [CH*IN_W-1:0]     non_inv = '0;
    logic [CH*GW-1:0]       gain = '0;
    logic [CH-1:0]          inv_mode = '0;
    logic                   sample_tick;
    logic                   out_valid;
    logic [CW-1:0]          out_chan;
    logic signed [IN_W-1:0] out_amp;
    logic [2*IN_W-1:0]      out_square;
    logic                   out_sat;
    logic                   overrun;

    op_amp_gain_array #(
        .CHANNELS(CH), .IN_W(IN_W), .GAIN_INT_W(GI), .GAIN_FRAC_W(GF), .DIV(DIV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .non_inv(non_inv), .gain(gain), .inv_mode(inv_mode),
        .sample_tick(sample_tick), .out_valid(out_valid), .out_ready(out_ready),
        .out_chan(out_chan), .out_amp(out_amp), .out_square(out_square),
        .out_sat(out_sat), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int     chan;
        longint amp;
        longint sq;
        bit     sat;
    } res_t;

    function automatic res_t ref_calc(input int c, input longint x, input longint g, input bit inv);
        res_t   r;
        longint one, geff, p, a, amax, amin;
        one  = longint'(1) << GF;
        amax = (longint'(1) << (IN_W - 1)) - 1;
        amin = -(longint'(1) << (IN_W - 1));
        geff = inv ? -g : g + one;
        p    = x * geff;
        a    = p / one;
        if (p < 0 && (p % one) != 0) a = a - 1;
        r.sat = 1'b0;
        if (a > amax) begin a = amax; r.sat = 1'b1; end
        if (a < amin) begin a = amin; r.sat = 1'b1; end
        r.amp  = a;
        r.sq   = a * a;
        r.chan = c;
        return r;
    endfunction

    // Reference model: pending results of the current frame, a countdown to the
    // next presentation, a free-running sample counter and the sticky overrun.
    res_t q[$];
    int   m_cnt  = 0;
    bit   m_busy = 1'b0;
    int   m_wait = 0;
    bit   m_ovr  = 1'b0;

    always @(posedge clk) begin
        bit tk, hs;
        if (reset) begin
            m_cnt  = 0;
            m_busy = 1'b0;
            m_wait = 0;
            m_ovr  = 1'b0;
            q.delete();
        end else begin
            tk = enable && (m_cnt == DIV - 1);
            hs = m_busy && (m_wait == 0) && out_ready;
            if (m_busy && m_wait > 0) m_wait--;
            if (tk) begin
                if (m_busy) begin
                    m_ovr = 1'b1;
                end else begin
                    for (int c = 0; c < CH; c++)
                        q.push_back(ref_calc(c, longint'($signed(non_inv[c*IN_W +: IN_W])),
                                             longint'(gain[c*GW +: GW]), inv_mode[c]));
                    m_busy = 1'b1;
                    m_wait = 2;
                end
            end
            if (hs) begin
                void'(q.pop_front());
                if (q.size() == 0) m_busy = 1'b0;
                else m_wait = 2;
            end
            m_cnt = (enable && m_cnt != DIV - 1) ? m_cnt + 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            check("reset_outs", {sample_tick, out_valid, out_chan, out_amp, out_square, out_sat, overrun}, 0);
        end else begin
            check("tick", sample_tick, enable && (m_cnt == DIV - 1));
            check("valid", out_valid, m_busy && (m_wait == 0));
            check("overrun", overrun, m_ovr);
            if (m_busy && m_wait == 0 && q.size() > 0) begin
                check("m_chan", out_chan, q[0].chan);
                check("m_amp", $signed(out_amp), q[0].amp);
                check("m_square", out_square, q[0].sq);
                check("m_sat", out_sat, q[0].sat);
            end
        end
    end

    int     l_amp[CH];
    longint l_sq[CH];
    bit     l_sat[CH];

    task automatic set_ch(input int c, input int x, input int g, input bit inv,
                          input int amp, input longint sq, input bit sat);
        non_inv[c*IN_W +: IN_W] = IN_W'(x);
        gain[c*GW +: GW]        = GW'(g);
        inv_mode[c]             = inv;
        l_amp[c] = amp;
        l_sq[c]  = sq;
        l_sat[c] = sat;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 200);
        check("tick_timeout", sample_tick, 1);
    endtask

    task automatic wait_valid(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 400);
        check("valid_timeout", out_valid, 1);
        check("chan_order", out_chan, c);
    endtask

    task automatic lit_chan(input int c);
        check("lit_amp", $signed(out_amp), l_amp[c]);
        check("lit_square", out_square, l_sq[c]);
        check("lit_sat", out_sat, l_sat[c]);
    endtask

    task automatic run_frame(output int ntk);
        int t0;
        wait_tick(ntk);
        t0 = cyc;
        for (int c = 0; c < CH; c++) begin
            wait_valid(c);
            if (c == 0) check("latency", cyc - t0, 3);
            lit_chan(c);
        end
    endtask

    task automatic set_fractional();
        set_ch(0, 1000, 'h180, 1'b0, 2500, 64'd6250000, 1'b0);
        set_ch(1, 1000, 'h180, 1'b1, -1500, 64'd2250000, 1'b0);
        set_ch(2, -3, 'h080, 1'b0, -5, 64'd25, 1'b0);
        set_ch(3, -3, 'h080, 1'b1, 1, 64'd1, 1'b0);
    endtask

    initial begin
        int ntk, t0, n_t, n_v;
        logic [63:0] hold_exp;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_overrun", overrun, 0);

        // Unity gain; first tick DIV cycles after release
        for (int c = 0; c < CH; c++) set_ch(c, 100, 0, 1'b0, 100, 64'd10000, 1'b0);
        reset = 1'b0;
        enable = 1'b1;
        out_ready = 1'b1;
        run_frame(ntk);
        check("first_tick_after_reset", ntk, DIV);

        @(posedge clk); #1;
        set_fractional();
        run_frame(ntk);

        @(posedge clk); #1;
        set_ch(0, 20000, 'h100, 1'b0, 32767, 64'd1073676289, 1'b1);
        set_ch(1, -32768, 'h100, 1'b1, 32767, 64'd1073676289, 1'b1);
        set_ch(2, -32768, 'h7FF, 1'b0, -32768, 64'd1073741824, 1'b1);
        set_ch(3, 5, 0, 1'b1, 0, 64'd0, 1'b0);
        run_frame(ntk);

        // Back-pressure on ch1 long enough for a tick to land mid-frame
        @(posedge clk); #1;
        set_fractional();
        wait_tick(ntk);
        wait_valid(0);
        lit_chan(0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_valid(1);
        lit_chan(1);
        @(posedge clk); #1;
        non_inv  = {$urandom, $urandom};
        gain     = {$urandom, $urandom};
        inv_mode = CH'($urandom);
        hold_exp = {1'b1, CW'(1), IN_W'(l_amp[1]), (2*IN_W)'(l_sq[1]), l_sat[1]};
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_hold", {out_valid, out_chan, out_amp, out_square, out_sat}, hold_exp);
        end
        check("overrun_set", overrun, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        wait_valid(2);
        lit_chan(2);
        wait_valid(3);
        lit_chan(3);
        @(negedge clk);
        check("overrun_sticky", overrun, 1);

        // Reset during ch2 presentation
        wait_tick(ntk);
        wait_valid(0);
        wait_valid(1);
        wait_valid(2);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_outs", {sample_tick, out_valid, out_chan, out_amp, out_square, out_sat, overrun}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_tick(ntk);
        check("tick_after_mid_reset", ntk, DIV);
        check("overrun_cleared", overrun, 0);
        t0 = cyc;
        wait_valid(0);
        check("latency_after_reset", cyc - t0, 3);
        wait_valid(1);
        wait_valid(2);
        wait_valid(3);

        // Enable low: no ticks, no results
        @(posedge clk); #1;
        enable = 1'b0;
        n_t = 0;
        n_v = 0;
        repeat (3 * DIV) begin
            @(negedge clk);
            if (sample_tick) n_t++;
            if (out_valid) n_v++;
        end
        check("disabled_ticks", n_t, 0);
        check("disabled_valids", n_v, 0);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_tick(ntk);
        check("tick_after_enable", ntk, DIV);
        for (int c = 0; c < CH; c++) wait_valid(c);

        // Randomized run; the reference model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            for (int c = 0; c < CH; c++) begin
                case ($urandom_range(0, 3))
                    0:       non_inv[c*IN_W +: IN_W] = {1'b1, {(IN_W - 1){1'b0}}};
                    1:       non_inv[c*IN_W +: IN_W] = {1'b0, {(IN_W - 1){1'b1}}};
                    default: non_inv[c*IN_W +: IN_W] = IN_W'($urandom);
                endcase
                gain[c*GW +: GW] = GW'($urandom_range(0, 2047));
                inv_mode[c]      = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            enable    = ($urandom_range(0, 199) != 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        enable    = 1'b1;
        repeat (40) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
